// File: rtl/seed_key_sched.sv
// -----------------------------------------------------------------------------
// seed_key_sched
//
// Purpose:
//   SEED round-key generator. On an accepted start it loads the 128-bit user
//   key and produces 16 64-bit round keys, one at a time. Each key is offered
//   to a downstream F-function stage with a valid/ready handshake.
//
// Ports:
//   i_Clk    - single clock; all state changes on the rising edge
//   i_Rst    - asynchronous, active-high reset
//   i_Key    - 128-bit user key K0||K1||K2||K3 (K0 = i_Key[127:96]); sampled
//              only when a start is accepted
//   i_Start  - start pulse; accepted only while idle or done
//   i_Ready  - downstream stage accepts the current round key
//   o_Key    - round key Ki,0||Ki,1 (Ki,0 in bits [63:32])
//   o_Valid  - o_Key and o_Round are valid
//   o_Round  - round index minus one (0..15)
//   o_Busy   - a schedule is in progress
//   o_Done   - all round keys of the current schedule have been accepted
// -----------------------------------------------------------------------------
module seed_key_sched #(
    parameter int ROUNDS = 16
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic [127:0] i_Key,
    input  logic         i_Start,
    input  logic         i_Ready,
    output logic [63:0]  o_Key,
    output logic         o_Valid,
    output logic [3:0]   o_Round,
    output logic         o_Busy,
    output logic         o_Done
);

    localparam logic [31:0] KC_INIT    = 32'h9E3779B9;
    localparam logic [3:0]  LAST_ROUND = 4'(ROUNDS - 1);

    localparam logic [7:0] M0 = 8'hFC;
    localparam logic [7:0] M1 = 8'hF3;
    localparam logic [7:0] M2 = 8'hCF;
    localparam logic [7:0] M3 = 8'h3F;

    // SEED 8-bit S-boxes, entry 0 first.
    localparam logic [0:255][7:0] SBOX1 = {
        128'hA985D6D3541DAC255D43181E51FCCA63,
        128'h2844209DE0E2C817A58F037BBB13D2EE,
        128'h708C3FA832DDF674EC950B575C5BBD01,
        128'h241C739810CCF2D92CE772839BD186C9,
        128'h6050A3EB0DB69E4FB75AC678A612AFD5,
        128'h61C3B441527D8D081F9900190453F7E1,
        128'hFD762F27B08B0EABA26E934D697C090A,
        128'hBFEFF3C58714FE64DE2E4B1A06216B66,
        128'h02F5928A0CB37ED07A4796E52680ADDF,
        128'hA13037AE36152238F4A7454C81E98497,
        128'h35CBCE3C7111C78975FBDAF8945982C4,
        128'hFF493967C0CFD7B80F8E4223916CDBA4,
        128'h34F148C26F3D2D40BE3EBCC1AABA4E55,
        128'h3BDC687F9CD84A5677A0ED46B52B65FA,
        128'hE3B9B19F5EF9E6B231EA6D5FE4F0CD88,
        128'h163A58D462290733E81B0579906A2A9A
    };

    localparam logic [0:255][7:0] SBOX2 = {
        128'h38E82DA6CFDEB3B8AF6055C7446F6B5B,
        128'hC36233B529A0E2A7D39111061CBC364B,
        128'hEF886CA817C416F4C245E1D63F3D8E98,
        128'h284EF63EA5F90DDFD82B667A272FF172,
        128'h42D441C07367AC8BF7AD801FCA2CAA34,
        128'hD20BEEE95D9418F857AE08C513CD86B9,
        128'hFF7DC131F58A6AB1D120D70222046871,
        128'h07DB9D9961BEE659DD5190DC9AA3ABD0,
        128'h810F471AE3EC8DBF967B5CA2A163234D,
        128'hC89E9C3A0C2EBA6E9F5AF292F34978CC,
        128'h15FB70757F351003646DC674D5B4EA09,
        128'h7619FE4012E0BD05FA01F02A5EA95643,
        128'h8514899BB0E5487997FC1E82218C1B5F,
        128'h7754B21D254F0046ED5852EB7EDAC9FD,
        128'h3095653CB6E4BB7C0E50392632846993,
        128'h37E724A4CB530A87D94C838FCE3B4AB7
    };

    // G function. Each substituted byte is spread over all four output bytes
    // through the rotating mask pattern, which is what the SS0..SS3 tables of
    // software implementations precompute.
    function automatic logic [31:0] seedG(input logic [31:0] x);
        logic [7:0] y0;
        logic [7:0] y1;
        logic [7:0] y2;
        logic [7:0] y3;
        y0 = SBOX1[x[7:0]];
        y1 = SBOX2[x[15:8]];
        y2 = SBOX1[x[23:16]];
        y3 = SBOX2[x[31:24]];
        seedG = {y0 & M3, y0 & M2, y0 & M1, y0 & M0}
              ^ {y1 & M0, y1 & M3, y1 & M2, y1 & M1}
              ^ {y2 & M1, y2 & M0, y2 & M3, y2 & M2}
              ^ {y3 & M2, y3 & M1, y3 & M0, y3 & M3};
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_State;
    state_t      w_NextState;

    logic [31:0] r_A;
    logic [31:0] r_B;
    logic [31:0] r_C;
    logic [31:0] r_D;
    logic [31:0] r_Kc;
    logic [3:0]  r_Round;
    logic [63:0] r_Key;
    logic        r_Valid;

    logic        w_Load;
    logic        w_Calc;
    logic        w_Advance;
    logic [31:0] w_T0;
    logic [31:0] w_T1;
    logic [63:0] w_AbRot;
    logic [63:0] w_CdRot;

    assign w_T0 = r_A + r_C - r_Kc;
    assign w_T1 = r_B - r_D + r_Kc;

    // A||B rotated right by 8 and C||D rotated left by 8.
    assign w_AbRot = {r_B[7:0], r_A, r_B[31:8]};
    assign w_CdRot = {r_C[23:0], r_D, r_C[31:24]};

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_State <= IDLE;
        end else begin
            r_State <= w_NextState;
        end
    end

    always_comb begin
        w_NextState = r_State;
        w_Load      = 1'b0;
        w_Calc      = 1'b0;
        w_Advance   = 1'b0;
        case (r_State)
            IDLE, DONE: begin
                if (i_Start) begin
                    w_Load      = 1'b1;
                    w_NextState = CALC;
                end
            end
            CALC: begin
                w_Calc      = 1'b1;
                w_NextState = HOLD;
            end
            HOLD: begin
                if (i_Ready) begin
                    w_Advance   = 1'b1;
                    w_NextState = (r_Round == LAST_ROUND) ? DONE : CALC;
                end
            end
            default: begin
                w_NextState = IDLE;
            end
        endcase
    end

    // Key state, round counter and output registers. The counter holds at
    // the last round once the schedule completes so o_Round reads 15 in DONE;
    // only a new start returns it to 0.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_A     <= '0;
            r_B     <= '0;
            r_C     <= '0;
            r_D     <= '0;
            r_Kc    <= '0;
            r_Round <= '0;
            r_Key   <= '0;
            r_Valid <= 1'b0;
        end else if (w_Load) begin
            r_A     <= i_Key[127:96];
            r_B     <= i_Key[95:64];
            r_C     <= i_Key[63:32];
            r_D     <= i_Key[31:0];
            r_Kc    <= KC_INIT;
            r_Round <= '0;
            r_Valid <= 1'b0;
        end else if (w_Calc) begin
            r_Key   <= {seedG(w_T0), seedG(w_T1)};
            r_Valid <= 1'b1;
        end else if (w_Advance) begin
            // r_Round is zero-based, so an even value means an odd round.
            if (!r_Round[0]) begin
                {r_A, r_B} <= w_AbRot;
            end else begin
                {r_C, r_D} <= w_CdRot;
            end
            r_Kc <= {r_Kc[30:0], r_Kc[31]};
            if (r_Round != LAST_ROUND) begin
                r_Round <= r_Round + 4'd1;
            end
            r_Valid <= 1'b0;
        end
    end

    assign o_Key   = r_Key;
    assign o_Valid = r_Valid;
    assign o_Round = r_Round;
    assign o_Busy  = (r_State == CALC) || (r_State == HOLD);
    assign o_Done  = (r_State == DONE);

endmodule

// File: tb/tb_seed_key_sched.sv
// -----------------------------------------------------------------------------
// tb_seed_key_sched
//
// Purpose:
//   Self-checking bench for seed_key_sched. Expected round keys come from a
//   software SEED key-schedule model kept here; each accepted key is also
//   pushed through a software F function with a fixed data block.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_seed_key_sched;

    logic         i_Clk = 1'b0;
    logic         i_Rst;
    logic [127:0] i_Key;
    logic         i_Start;
    logic         i_Ready;
    logic [63:0]  o_Key;
    logic         o_Valid;
    logic [3:0]   o_Round;
    logic         o_Busy;
    logic         o_Done;

    seed_key_sched #(.ROUNDS(16)) dut (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Key   (i_Key),
        .i_Start (i_Start),
        .i_Ready (i_Ready),
        .o_Key   (o_Key),
        .o_Valid (o_Valid),
        .o_Round (o_Round),
        .o_Busy  (o_Busy),
        .o_Done  (o_Done)
    );

    always #5 i_Clk = ~i_Clk;

    localparam logic [63:0] F_DATA = 64'h0123456789ABCDEF;

    localparam logic [0:255][7:0] REF_S1 = {
        128'hA985D6D3541DAC255D43181E51FCCA63, 128'h2844209DE0E2C817A58F037BBB13D2EE,
        128'h708C3FA832DDF674EC950B575C5BBD01, 128'h241C739810CCF2D92CE772839BD186C9,
        128'h6050A3EB0DB69E4FB75AC678A612AFD5, 128'h61C3B441527D8D081F9900190453F7E1,
        128'hFD762F27B08B0EABA26E934D697C090A, 128'hBFEFF3C58714FE64DE2E4B1A06216B66,
        128'h02F5928A0CB37ED07A4796E52680ADDF, 128'hA13037AE36152238F4A7454C81E98497,
        128'h35CBCE3C7111C78975FBDAF8945982C4, 128'hFF493967C0CFD7B80F8E4223916CDBA4,
        128'h34F148C26F3D2D40BE3EBCC1AABA4E55, 128'h3BDC687F9CD84A5677A0ED46B52B65FA,
        128'hE3B9B19F5EF9E6B231EA6D5FE4F0CD88, 128'h163A58D462290733E81B0579906A2A9A
    };

    localparam logic [0:255][7:0] REF_S2 = {
        128'h38E82DA6CFDEB3B8AF6055C7446F6B5B, 128'hC36233B529A0E2A7D39111061CBC364B,
        128'hEF886CA817C416F4C245E1D63F3D8E98, 128'h284EF63EA5F90DDFD82B667A272FF172,
        128'h42D441C07367AC8BF7AD801FCA2CAA34, 128'hD20BEEE95D9418F857AE08C513CD86B9,
        128'hFF7DC131F58A6AB1D120D70222046871, 128'h07DB9D9961BEE659DD5190DC9AA3ABD0,
        128'h810F471AE3EC8DBF967B5CA2A163234D, 128'hC89E9C3A0C2EBA6E9F5AF292F34978CC,
        128'h15FB70757F351003646DC674D5B4EA09, 128'h7619FE4012E0BD05FA01F02A5EA95643,
        128'h8514899BB0E5487997FC1E82218C1B5F, 128'h7754B21D254F0046ED5852EB7EDAC9FD,
        128'h3095653CB6E4BB7C0E50392632846993, 128'h37E724A4CB530A87D94C838FCE3B4AB7
    };

    typedef struct {
        logic [127:0] key;
        int           round;
        logic [63:0]  expKey;
    } vec_t;

    int          vectorCount = 0;
    int          missCount   = 0;
    logic [63:0] expKeys [16];
    logic [63:0] gotKeys [16];
    vec_t        vecs [5];

    // Output byte k of G is the XOR over input bytes j of S(xj) & m[(j+k)%4].
    function automatic logic [31:0] refG(input logic [31:0] x);
        logic [7:0] m [4];
        logic [7:0] y [4];
        logic [7:0] z [4];
        m = '{8'hFC, 8'hF3, 8'hCF, 8'h3F};
        y[0] = REF_S1[x[7:0]];
        y[1] = REF_S2[x[15:8]];
        y[2] = REF_S1[x[23:16]];
        y[3] = REF_S2[x[31:24]];
        for (int k = 0; k < 4; k++) begin
            z[k] = 8'h00;
            for (int j = 0; j < 4; j++) begin
                z[k] = z[k] ^ (y[j] & m[(j + k) % 4]);
            end
        end
        return {z[3], z[2], z[1], z[0]};
    endfunction

    // SEED F function applied to data block r0||r1 with round key k.
    function automatic logic [63:0] refF(input logic [63:0] k, input logic [63:0] data);
        logic [31:0] c;
        logic [31:0] d;
        c = data[63:32] ^ k[63:32];
        d = data[31:0] ^ k[31:0];
        d = refG(d ^ c);
        c = refG(c + d);
        d = refG(d + c);
        c = c + d;
        return {c, d};
    endfunction

    task automatic modelKeys(input logic [127:0] key);
        logic [63:0] ab;
        logic [63:0] cd;
        logic [31:0] kc;
        logic [31:0] t0;
        logic [31:0] t1;
        ab = key[127:64];
        cd = key[63:0];
        kc = 32'h9E3779B9;
        for (int i = 0; i < 16; i++) begin
            t0 = ab[63:32] + cd[63:32] - kc;
            t1 = ab[31:0] - cd[31:0] + kc;
            expKeys[i] = {refG(t0), refG(t1)};
            if (i % 2 == 0) ab = (ab >> 8) | (ab << 56);
            else            cd = (cd << 8) | (cd >> 56);
            kc = (kc << 1) | (kc >> 31);
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic [127:0] key, input logic ready);
        i_Start = start;
        i_Key   = key;
        i_Ready = ready;
    endtask

    task automatic stepCycle();
        @(posedge i_Clk);
        #1;
    endtask

    // Runs one schedule from an accepted start. Optional corner cases:
    // stall i_Ready at stallRound for stallLen cycles, pulse i_Start during
    // HOLD of pokeRound, or assert reset during abortRound.
    task automatic runSchedule(input logic [127:0] key, input int stallRound, input int stallLen,
                               input int pokeRound, input int abortRound);
        int   waits;
        logic pokeActive;
        modelKeys(key);
        pokeActive = 1'b0;
        applyStimulus(1'b1, key, 1'b1);
        stepCycle();
        applyStimulus(1'b0, ~key, 1'b1);
        for (int r = 1; r <= 16; r++) begin
            waits = 0;
            while (o_Valid !== 1'b1 && waits < 8) begin
                stepCycle();
                waits++;
            end
            if (pokeActive) begin
                i_Start    = 1'b0;
                pokeActive = 1'b0;
            end
            checkOutput($sformatf("latency r%0d", r), 64'(waits), 64'd1);
            if (o_Valid !== 1'b1) return;
            checkOutput($sformatf("key r%0d", r), o_Key, expKeys[r-1]);
            checkOutput($sformatf("round r%0d", r), 64'(o_Round), 64'(r - 1));
            checkOutput($sformatf("busy/done r%0d", r), 64'({o_Busy, o_Done}), 64'd2);
            checkOutput($sformatf("F out r%0d", r), refF(o_Key, F_DATA), refF(expKeys[r-1], F_DATA));
            gotKeys[r-1] = o_Key;
            if (r == abortRound) begin
                #2 i_Rst = 1'b1;
                #1;
                checkOutput("reset key", o_Key, 64'd0);
                checkOutput("reset flags", 64'({o_Valid, o_Round, o_Busy, o_Done}), 64'd0);
                stepCycle();
                i_Rst = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    stepCycle();
                    checkOutput("post-reset idle", 64'({o_Valid, o_Busy, o_Done}), 64'd0);
                end
                return;
            end
            if (r == stallRound) begin
                i_Ready = 1'b0;
                for (int k = 0; k < stallLen; k++) begin
                    stepCycle();
                    checkOutput($sformatf("stall key r%0d", r), o_Key, expKeys[r-1]);
                    checkOutput($sformatf("stall flags r%0d", r), 64'({o_Valid, o_Round}), 64'({1'b1, 4'(r - 1)}));
                end
                i_Ready = 1'b1;
            end
            if (r == pokeRound) begin
                i_Start = 1'b1;
                i_Key   = ~key;
                i_Ready = 1'b0;
                stepCycle();
                checkOutput($sformatf("poke key r%0d", r), o_Key, expKeys[r-1]);
                i_Ready    = 1'b1;
                pokeActive = 1'b1;
            end
            stepCycle();
        end
        i_Start = 1'b0;
        checkOutput("done flags", 64'({o_Valid, o_Busy, o_Done}), 64'd1);
        checkOutput("done round", 64'(o_Round), 64'd15);
        checkOutput("done key", o_Key, expKeys[15]);
        stepCycle();
        checkOutput("done hold", 64'({o_Valid, o_Round, o_Busy, o_Done}), 64'({1'b0, 4'd15, 1'b0, 1'b1}));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] rndKey;
        applyStimulus(1'b0, 128'd0, 1'b0);
        i_Rst = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("reset state key", o_Key, 64'd0);
        checkOutput("reset state flags", 64'({o_Valid, o_Round, o_Busy, o_Done}), 64'd0);
        i_Rst = 1'b0;
        i_Ready = 1'b1;
        stepCycle();
        checkOutput("idle ready ignored", 64'({o_Valid, o_Busy, o_Done}), 64'd0);

        vecs[0] = '{128'd0, 1, 64'h7C8F8C7EC737A22C};
        vecs[1] = '{128'd0, 2, 64'hFF276CDBA7CA684A};
        for (int i = 2; i < 5; i++) begin
            rndKey = {$urandom(), $urandom(), $urandom(), $urandom()};
            vecs[i].key   = rndKey;
            vecs[i].round = $urandom_range(1, 16);
            modelKeys(rndKey);
            vecs[i].expKey = expKeys[vecs[i].round - 1];
        end
        for (int i = 0; i < 5; i++) begin
            runSchedule(vecs[i].key, 0, 0, 0, 0);
            checkOutput($sformatf("table %0d", i), gotKeys[vecs[i].round - 1], vecs[i].expKey);
        end

        runSchedule(128'd0, 3, 5, 0, 0);
        runSchedule(128'd0, 0, 0, 4, 0);
        checkOutput("poke run r2", gotKeys[1], 64'hFF276CDBA7CA684A);
        runSchedule(128'h000102030405060708090A0B0C0D0E0F, 0, 0, 0, 0);
        runSchedule(128'd0, 0, 0, 0, 9);
        runSchedule(128'd0, 0, 0, 0, 0);
        checkOutput("restart r1", gotKeys[0], 64'h7C8F8C7EC737A22C);

        for (int n = 0; n < 3; n++) begin
            rndKey = {$urandom(), $urandom(), $urandom(), $urandom()};
            runSchedule(rndKey, $urandom_range(1, 16), $urandom_range(1, 4), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/seed_key_sched.md
SEED_KEY_SCHED -- requirements
Module: seed_key_sched

Interface
REQ-001 SHALL have parameter ROUNDS, default 16, giving the number of round keys produced per key; only 16 is supported.
REQ-002 SHALL have port i_Clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_Rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port i_Key, input, 128 bits: user key K0||K1||K2||K3, with K0 = i_Key[127:96]; sampled only on an accepted start.
REQ-005 SHALL have port i_Start, input, 1 bit: start pulse; accepted only in IDLE or DONE.
REQ-006 SHALL have port i_Ready, input, 1 bit: downstream F-function stage accepts the current round key.
REQ-007 SHALL have port o_Key, output, 64 bits: round key Ki,0||Ki,1, laid out as the 64-bit key operand of the F-function stage.
REQ-008 SHALL have port o_Valid, output, 1 bit: o_Key and o_Round are valid.
REQ-009 SHALL have port o_Round, output, 4 bits: round index minus 1 (0..15).
REQ-010 SHALL have port o_Busy, output, 1 bit: high in CALC and HOLD.
REQ-011 SHALL have port o_Done, output, 1 bit: high in DONE.

Function
REQ-012 SHALL implement the states IDLE, CALC, HOLD and DONE.
REQ-013 SHALL, in IDLE or DONE with i_Start=1, load A,B,C,D from i_Key, load KC=32'h9E3779B9, clear the round counter and enter CALC.
REQ-014 SHALL, in CALC, compute T0=(A+C-KC) mod 2^32 and T1=(B-D+KC) mod 2^32, register o_Key = G(T0)||G(T1), set o_Valid=1 and enter HOLD.
REQ-015 SHALL compute G with the SEED S-boxes SS0..SS3 and masks m0=FC, m1=F3, m2=CF, m3=3F, implemented combinationally (one G instance per half, or one shared instance over two CALC cycles, but latency per REQ-017).
REQ-016 SHALL, in HOLD, keep o_Key, o_Round and o_Valid stable until i_Ready=1 (valid/ready handshake; no retraction).
REQ-017 SHALL make the first o_Valid rise exactly 2 cycles after the cycle in which i_Start is accepted; with i_Ready tied high, a new key SHALL appear every 2 cycles.
REQ-018 SHALL, on handshake in HOLD for round r (1-based): if r is odd, rotate A||B right by 8; if r is even, rotate C||D left by 8; rotate KC left by 1; increment the counter; drop o_Valid; enter CALC if r<16, otherwise enter DONE.
REQ-019 SHALL hold o_Key at its last value in DONE, with o_Valid=0.
REQ-020 SHALL ignore i_Start in CALC and HOLD: no restart and no corruption of the sequence.
REQ-021 SHALL ignore i_Ready when o_Valid=0.
REQ-022 SHALL never advance the round counter past 15; the counter does not wrap to 0 except on an accepted start.
REQ-023 SHALL, on i_Start accepted in DONE, restart at round 1 with the newly sampled key.

Reset
REQ-024 SHALL, while i_Rst=1 at any time (including mid-sequence), immediately force state IDLE, o_Key=0, o_Valid=0, o_Round=0, o_Busy=0, o_Done=0 and A,B,C,D,KC=0.
REQ-025 SHALL, after i_Rst deasserts, require a new i_Start before any further output.

Verification
REQ-026 Bench SHALL cover this scenario: i_Key=0, i_Start pulse, i_Ready=1 -> round 1 o_Key=64'h7C8F8C7E_C737A22C, round 2 o_Key=64'hFF276CDB_A7CA684A, 16 valids 2 cycles apart, then o_Done=1.
REQ-027 Bench SHALL cover this scenario: i_Key=0, with i_Ready held low 5 cycles at round 3 -> o_Key and o_Round=2 stable for all 5 cycles, and no skipped or repeated rounds.
REQ-028 Bench SHALL cover this scenario: i_Start pulsed during HOLD of round 4 -> sequence unaffected, and the round keys match the REQ-026 sequence.
REQ-029 Bench SHALL cover this scenario: i_Rst asserted during round 9 -> all outputs are 0 within the same cycle; a later start with i_Key=0 reproduces round 1 = 64'h7C8F8C7E_C737A22C.
REQ-030 Bench SHALL cover this scenario: i_Start in DONE with i_Key=128'h000102030405060708090A0B0C0D0E0F -> 16 keys matching the software SEED reference model.
REQ-031 Bench SHALL cover this scenario: each o_Key is fed to the F-function stage with a fixed i_Data -> its output matches the software model per round.
